decoder_arbiter: RTL and testbench
==================================

# decoder_arbiter

Round-robin arbiter that shares the 2-to-4 `decoder` between four requesters. It picks one requester, drives the winner's 2-bit index through `decoder` to form a one-hot grant, and holds the grant until the requester drops its request or a hold timeout expires. It sits between the requesting agents and the shared one-hot resource-select lines.

## Interface
- `MAX_HOLD`, default 8: maximum grant length in cycles; legal range 1 to 2^`CNT_W`-1.
- `CNT_W`, default 4: width of the hold counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: request vector; `req[i]` is held high by requester i until it is done.
- `gnt` out 4: one-hot grant; all zero when no grant is active.
- `gnt_id` out 2: index of the current or last granted requester.
- `busy` out 1: high in states GRANT and RELEASE.
- `timeout` out 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- States are IDLE, GRANT and RELEASE. Registers are `state`, `ptr[1:0]`, `gnt_id[1:0]`, `hold_cnt[CNT_W-1:0]` and `timeout`.
- Reset (sync, `rst`=1): state becomes IDLE; `ptr`, `gnt_id`, `hold_cnt`, `gnt`, `busy` and `timeout` all become 0. Reset has priority over every transition.
- IDLE:
  - If `req` is nonzero, select the first i with `req[i]`=1, searching from `ptr` upward modulo 4.
  - Load `gnt_id` with i and `hold_cnt` with 1, then go to GRANT.
  - If `req` is zero, stay in IDLE.
- GRANT:
  - `gnt` is the `decoder` output for `gnt_id`: `gnt[0]` is out1 (for 00), through `gnt[3]` is out4 (for 11). `gnt_id[0]` drives inp1 and `gnt_id[1]` drives inp2.
  - If `req[gnt_id]`=0: go to RELEASE, with `timeout` staying 0.
  - Else if `hold_cnt`==`MAX_HOLD`: go to RELEASE and set `timeout`=1 for the next cycle only.
  - Else: increment `hold_cnt` and stay in GRANT.
  - Requests from other requesters are ignored while a grant is active. There is no preemption.
- RELEASE:
  - `gnt`=0.
  - `ptr` was loaded with `gnt_id`+1 (mod 4, so 3 wraps to 0) on entry to RELEASE.
  - Always go to IDLE next cycle.
- `timeout` is registered and is high only during the first RELEASE cycle after a forced revoke.
- A requester that timed out and keeps requesting becomes lowest priority, because `ptr` has moved past it.
- `gnt` and `timeout` are never high in the same cycle.
- `gnt_id` holds its value outside GRANT.

## Timing
- Grant latency: `req` is sampled high in IDLE at edge N, and `gnt` is high from cycle N+1.
- Release latency: `req[gnt_id]` is sampled low at edge M, and `gnt` is low from cycle M+1.
- Minimum gap between consecutive grants is 2 cycles with `gnt`=0 (RELEASE, then IDLE).
- A grant lasts at most `MAX_HOLD` cycles. With `MAX_HOLD`=1, the grant is exactly one cycle unless the request drops earlier.
- Sampling rule: if a requester drops `req` in the same cycle the counter reaches `MAX_HOLD`, the request drop wins and `timeout` stays 0.
- Reset asserted mid-GRANT: `gnt`=0 from the next cycle, `timeout` stays 0, and `ptr` returns to 0.
- `gnt` is combinational from registered state and `gnt_id` only. There is no combinational path from `req` to `gnt`.

## Structure
- Shared package or header: state encodings (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2) and the requester count 4.
- One sub-module: the existing `decoder`, instantiated once to map `gnt_id` to one-hot. Its outputs are ANDed with (state==GRANT) to form `gnt`.
- The round-robin search is a small combinational priority function inside `decoder_arbiter`.

## Test plan
- **Reset, then a single request:** with `rst` held 2 cycles then released and `req`=0100, `gnt`=0100 and `gnt_id`=2 one cycle later. Dropping `req` gives `gnt`=0000 one cycle later, with `busy` high through the RELEASE cycle.
- **Round-robin fairness:** with `req`=1111 held and each requester dropping after 2 granted cycles, grants occur in the order 0,1,2,3,0. Each grant is separated by 2 idle cycles.
- **Timeout:** with `MAX_HOLD`=8 and `req`=0001 held forever, `gnt`=0001 for exactly 8 cycles, then `timeout`=1 for 1 cycle. The next grant also goes to requester 0, since it is the only requester.
- **Timeout with contention:** with `req`=0011 held, requester 0 times out, and the next grant is `gnt`=0010.
- **Simultaneous drop and limit:** when `req` drops on the same edge that `hold_cnt`==`MAX_HOLD`, `timeout` stays 0 and the release is normal.
- **Reset mid-grant:** asserting `rst` during GRANT with `gnt_id`=3 gives all outputs 0 the next cycle. After release with `req`=1000, requester 3 is granted.

Source files
------------

// File: rtl/decoder_arbiter_pkg.sv
// rtl/decoder_arbiter_pkg.sv - shared encodings for the round-robin decoder arbiter
// Purpose: FSM state encoding and requester count used by the arbiter, its
//          interface and its decoder.
// Ports:   none (package).
package decoder_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_arbiter_if.sv
// rtl/decoder_arbiter_if.sv - request/grant bundle between requesters and the arbiter
// Purpose: groups the request vector and the grant-side outputs.
// Signals: req     - request vector, bit i held high by requester i
//          gnt     - one-hot grant, zero when no grant is active
//          gnt_id  - index of current or last granted requester
//          busy    - arbiter in GRANT or RELEASE
//          timeout - one-cycle pulse when a grant is forcibly revoked
// Modports: master (requester side), slave (arbiter side).
interface decoder_arbiter_if;
    import decoder_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               busy;
    logic               timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );

endinterface

// File: rtl/decoder_arbiter_decoder.sv
// rtl/decoder_arbiter_decoder.sv - 2-to-4 one-hot decoder shared by the requesters
// Purpose: maps a 2-bit index onto four one-hot select lines.
// Ports:   inp1 - index bit 0
//          inp2 - index bit 1
//          out1..out4 - one-hot outputs for index 00, 01, 10, 11
module decoder_arbiter_decoder (
    input  logic inp1,
    input  logic inp2,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4
);

    assign out1 = ~inp2 & ~inp1;
    assign out2 = ~inp2 &  inp1;
    assign out3 =  inp2 & ~inp1;
    assign out4 =  inp2 &  inp1;

endmodule

// File: rtl/decoder_arbiter.sv
// rtl/decoder_arbiter.sv - round-robin arbiter granting one of four requesters
// Purpose: picks a requester round-robin, drives its index through the shared
//          decoder to form a one-hot grant, and holds the grant until the
//          request drops or MAX_HOLD cycles have elapsed.
// Parameters: MAX_HOLD - maximum grant length in cycles (1 .. 2^CNT_W-1)
//             CNT_W    - width of the hold counter
// Ports:   clk - clock, rising edge
//          rst - synchronous active-high reset
//          bus - decoder_arbiter_if.slave (req in; gnt, gnt_id, busy, timeout out)
module decoder_arbiter
    import decoder_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_arbiter_if.slave     bus
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] dec_onehot;
    logic [ID_W-1:0]    pick;

    // First set bit of r at or above p, wrapping modulo 4. Walking offsets
    // from high to low lets the smallest offset overwrite the result last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    p);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] res;
        res = p;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = p + ID_W'(k);
            if (r[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

    assign pick = rr_pick(bus.req, ptr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gnt_id_q   <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_id_q   <= gnt_id_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_id_d   = gnt_id_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    gnt_id_d   = pick;
                    hold_cnt_d = CNT_W'(1);
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A dropped request is checked first so that a drop on the
                // limit cycle counts as a normal release, not a timeout.
                if (!bus.req[gnt_id_q]) begin
                    state_d = ST_RELEASE;
                    ptr_d   = gnt_id_q + ID_W'(1);
                end else if (hold_cnt_q == CNT_W'(MAX_HOLD)) begin
                    state_d   = ST_RELEASE;
                    ptr_d     = gnt_id_q + ID_W'(1);
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    decoder_arbiter_decoder u_decoder (
        .inp1 (gnt_id_q[0]),
        .inp2 (gnt_id_q[1]),
        .out1 (dec_onehot[0]),
        .out2 (dec_onehot[1]),
        .out3 (dec_onehot[2]),
        .out4 (dec_onehot[3])
    );

    // Grant depends only on registered state, never directly on req.
    assign bus.gnt     = dec_onehot & {NUM_REQ{state_q == ST_GRANT}};
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = (state_q == ST_GRANT) || (state_q == ST_RELEASE);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_decoder_arbiter.sv
// tb/tb_decoder_arbiter.sv - self-checking bench for decoder_arbiter
module tb_decoder_arbiter;

    localparam int TB_MAX_HOLD = 8;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    // reference model state
    int m_state = 0;   // 0 idle, 1 grant, 2 release
    int m_ptr   = 0;
    int m_id    = 0;
    int m_cnt   = 0;
    int m_to    = 0;

    decoder_arbiter_if bus ();

    decoder_arbiter #(
        .MAX_HOLD (TB_MAX_HOLD),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic rs);
        bit found;
        if (rs) begin
            m_state = 0; m_ptr = 0; m_id = 0; m_cnt = 0; m_to = 0;
        end else begin
            m_to = 0;
            case (m_state)
                0: if (r != 4'b0000) begin
                    found = 0;
                    for (int k = 0; k < 4; k++) begin
                        int idx;
                        idx = (m_ptr + k) % 4;
                        if (!found && r[idx]) begin
                            m_id  = idx;
                            found = 1;
                        end
                    end
                    m_cnt   = 1;
                    m_state = 1;
                end
                1: if (!r[m_id]) begin
                    m_state = 2;
                    m_ptr   = (m_id + 1) % 4;
                end else if (m_cnt == TB_MAX_HOLD) begin
                    m_state = 2;
                    m_to    = 1;
                    m_ptr   = (m_id + 1) % 4;
                end else begin
                    m_cnt = m_cnt + 1;
                end
                default: m_state = 0;
            endcase
        end
    endtask

    // Drive one cycle of stimulus (called just after a falling edge), push the
    // expected post-edge outputs, then pop and compare at the next falling edge.
    task automatic cyc(input logic [3:0] r, input logic rs, input string tag);
        exp_t e;
        bus.req = r;
        rst     = rs;
        model_step(r, rs);
        e.gnt  = (m_state == 1) ? 4'(1 << m_id) : 4'b0000;
        e.id   = 2'(m_id);
        e.busy = (m_state != 0);
        e.to   = (m_to != 0);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, "_gnt"},     32'(bus.gnt),     32'(e.gnt));
        check({tag, "_gnt_id"},  32'(bus.gnt_id),  32'(e.id));
        check({tag, "_busy"},    32'(bus.busy),    32'(e.busy));
        check({tag, "_timeout"}, 32'(bus.timeout), 32'(e.to));
    endtask

    initial begin
        int gcount;
        int tcount;
        int next_id;
        bit seen_to;
        bit got_next;

        bus.req = 4'b0000;
        rst     = 1'b1;
        @(negedge clk);

        // reset, then a single request
        cyc(4'b0000, 1'b1, "rst0");
        cyc(4'b0000, 1'b1, "rst1");
        check("reset_gnt", 32'(bus.gnt), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        cyc(4'b0100, 1'b0, "single_req");
        check("single_gnt", 32'(bus.gnt), 32'h4);
        check("single_id", 32'(bus.gnt_id), 32'h2);
        cyc(4'b0100, 1'b0, "single_hold");
        cyc(4'b0000, 1'b0, "single_drop");
        check("single_rel_gnt", 32'(bus.gnt), 32'h0);
        check("single_rel_busy", 32'(bus.busy), 32'h1);
        cyc(4'b0000, 1'b0, "single_idle");

        // round-robin fairness: each grant held 2 cycles, then dropped
        cyc(4'b0000, 1'b1, "rr_rst");
        for (int i = 0; i < 5; i++) begin
            logic [3:0] mask;
            mask = 4'b1111;
            mask[i % 4] = 1'b0;
            cyc(4'b1111, 1'b0, "rr_grant");
            check("rr_order", 32'(bus.gnt_id), 32'(i % 4));
            cyc(4'b1111, 1'b0, "rr_hold");
            cyc(mask, 1'b0, "rr_drop");
            cyc(4'b1111, 1'b0, "rr_gap");
        end

        // timeout with a single persistent requester
        cyc(4'b0000, 1'b1, "to_rst");
        gcount = 0; tcount = 0; next_id = -1; seen_to = 0; got_next = 0;
        for (int n = 0; n < 20; n++) begin
            cyc(4'b0001, 1'b0, "to_run");
            if (bus.gnt != 4'b0000 && !seen_to) gcount++;
            if (seen_to && !got_next && bus.gnt != 4'b0000) begin
                next_id  = int'(bus.gnt_id);
                got_next = 1;
            end
            if (bus.timeout) begin
                tcount++;
                seen_to = 1;
            end
        end
        check("to_grant_len", 32'(gcount), 32'(TB_MAX_HOLD));
        check("to_pulses", 32'(tcount), 32'd2);
        check("to_next_id", 32'(next_id), 32'd0);

        // timeout with contention: requester 1 follows requester 0
        cyc(4'b0000, 1'b1, "tc_rst");
        seen_to = 0;
        for (int n = 0; n < 30 && !seen_to; n++) begin
            cyc(4'b0011, 1'b0, "tc_run");
            if (bus.timeout) seen_to = 1;
        end
        check("tc_timeout_seen", 32'(seen_to), 32'd1);
        cyc(4'b0011, 1'b0, "tc_idle");
        cyc(4'b0011, 1'b0, "tc_next");
        check("tc_next_gnt", 32'(bus.gnt), 32'h2);

        // request drop on the same edge the counter reaches the limit
        cyc(4'b0000, 1'b1, "sd_rst");
        for (int n = 0; n < TB_MAX_HOLD; n++) begin
            cyc(4'b0001, 1'b0, "sd_hold");
        end
        cyc(4'b0000, 1'b0, "sd_drop");
        check("sd_timeout", 32'(bus.timeout), 32'd0);
        check("sd_busy", 32'(bus.busy), 32'd1);

        // reset in the middle of a grant to requester 3
        cyc(4'b0000, 1'b1, "rm_rst0");
        cyc(4'b1000, 1'b0, "rm_grant");
        check("rm_gnt3", 32'(bus.gnt), 32'h8);
        cyc(4'b1000, 1'b0, "rm_hold");
        cyc(4'b1000, 1'b1, "rm_rst");
        check("rm_gnt_zero", 32'(bus.gnt), 32'h0);
        check("rm_id_zero", 32'(bus.gnt_id), 32'h0);
        cyc(4'b1000, 1'b0, "rm_regrant");
        check("rm_regrant_id", 32'(bus.gnt_id), 32'h3);

        // random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r;
            logic       rs;
            r  = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 49) == 0);
            cyc(r, rs, "rand");
            check("rand_excl", 32'(bus.gnt != 4'b0000 && bus.timeout), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
